// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared types and constants for the core run controller
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_FREE  = 2'd0,
    MODE_START = 2'd1,
    MODE_STEP  = 2'd2,
    MODE_GATED = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_RESET_HOLD,
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_HALTED
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/trigger_sync.sv
// rtl/trigger_sync.sv - push-button synchroniser with rising-edge detect
module trigger_sync
  import run_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic trigger_in,
  output logic level,
  output logic trig_edge
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], trigger_in};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  // The third flop only delays the synchronised level for edge detection.
  assign level     = sync_q[SYNC_STAGES-1];
  assign trig_edge = level & ~dly_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run-mode FSM, core reset/enable, cycle counter and a0 snapshot
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [1:0]       mode,
  input  logic             halt_in,
  input  logic [XLEN-1:0]  a0_in,
  output logic             core_en,
  output logic             core_rst,
  output logic [XLEN-1:0]  a0_out,
  output logic             a0_valid,
  output logic [CNT_W-1:0] cycle_count,
  output logic             halted
);

  localparam int              HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES - 1);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [XLEN-1:0]   a0_q, a0_d;
  logic              a0_valid_q, a0_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              trig_level, trig_edge;
  logic              en;

  trigger_sync u_trigger_sync (
    .clk        (clk),
    .rst        (rst),
    .trigger_in (trigger),
    .level      (trig_level),
    .trig_edge  (trig_edge)
  );

  assign en = (state_q == ST_RUN) || (state_q == ST_STEP);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_RESET_HOLD: begin
        if (hold_q == '0) begin
          mode_d  = mode_t'(mode);
          state_d = (mode_t'(mode) == MODE_FREE) ? ST_RUN : ST_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_IDLE: begin
        case (mode_q)
          MODE_START: if (trig_edge)  state_d = ST_RUN;
          MODE_STEP:  if (trig_edge)  state_d = ST_STEP;
          MODE_GATED: if (trig_level) state_d = ST_RUN;
          default: ;
        endcase
      end
      ST_RUN: begin
        // A halt wins over the gate dropping in the same cycle.
        if (halt_in) begin
          state_d = ST_HALTED;
        end else if ((mode_q == MODE_GATED) && !trig_level) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: state_d = halt_in ? ST_HALTED : ST_IDLE;
      ST_HALTED: begin
        if (trig_edge) begin
          state_d = ST_RESET_HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      default: state_d = ST_RESET_HOLD;
    endcase
  end

  always_comb begin
    a0_d       = a0_q;
    a0_valid_d = 1'b0;
    cnt_d      = cnt_q;
    if (en) begin
      a0_d       = a0_in;
      a0_valid_d = (a0_in != a0_q);
    end
    if (state_q == ST_RESET_HOLD) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RESET_HOLD;
      mode_q     <= MODE_FREE;
      hold_q     <= HOLD_INIT;
      a0_q       <= '0;
      a0_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      hold_q     <= hold_d;
      a0_q       <= a0_d;
      a0_valid_q <= a0_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign core_en     = en;
  assign core_rst    = (state_q == ST_RESET_HOLD);
  assign halted      = (state_q == ST_HALTED);
  assign a0_out      = a0_q;
  assign a0_valid    = a0_valid_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed and randomized checks of cpu_run_ctrl against a reference model
module tb_cpu_run_ctrl;

  localparam int XLEN       = 32;
  localparam int CNT_W      = 4;
  localparam int RST_CYCLES = 4;
  localparam int MAXC       = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             trigger;
  logic [1:0]       mode;
  logic             halt_in;
  logic [XLEN-1:0]  a0_in;
  logic             core_en;
  logic             core_rst;
  logic [XLEN-1:0]  a0_out;
  logic             a0_valid;
  logic [CNT_W-1:0] cycle_count;
  logic             halted;

  cpu_run_ctrl #(
    .XLEN       (XLEN),
    .CNT_W      (CNT_W),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .mode        (mode),
    .halt_in     (halt_in),
    .a0_in       (a0_in),
    .core_en     (core_en),
    .core_rst    (core_rst),
    .a0_out      (a0_out),
    .a0_valid    (a0_valid),
    .cycle_count (cycle_count),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases named after the controller's documented states,
  // trigger conditioning as a 3-deep history of sampled pin values.
  typedef enum {M_HOLD, M_IDLE, M_RUN, M_STEP, M_HALT} phase_t;
  phase_t          ph = M_HOLD;
  int              hold_left = 0;
  int              m_mode = 0;
  int              m_cnt = 0;
  logic [XLEN-1:0] m_a0 = '0;
  bit              m_valid = 0;
  bit [2:0]        hist = '0;
  bit              live = 0;

  task automatic model_step();
    bit en, lvl, edg;
    en = (ph == M_RUN) || (ph == M_STEP);
    if (rst) begin
      ph = M_HOLD; hold_left = RST_CYCLES - 1; m_a0 = '0; m_valid = 0;
      m_cnt = 0; hist = '0; live = 1;
    end else if (live) begin
      lvl = hist[1];
      edg = hist[1] && !hist[2];
      if (en) begin m_valid = (a0_in != m_a0); m_a0 = a0_in; end
      else m_valid = 0;
      if (ph == M_HOLD) m_cnt = 0;
      else if (en && m_cnt < MAXC) m_cnt = m_cnt + 1;
      case (ph)
        M_HOLD: if (hold_left == 0) begin
                  m_mode = int'(mode);
                  ph = (m_mode == 0) ? M_RUN : M_IDLE;
                end else hold_left = hold_left - 1;
        M_IDLE: begin
                  if (m_mode == 1 && edg) ph = M_RUN;
                  if (m_mode == 2 && edg) ph = M_STEP;
                  if (m_mode == 3 && lvl) ph = M_RUN;
                end
        M_RUN:  if (halt_in) ph = M_HALT;
                else if (m_mode == 3 && !lvl) ph = M_IDLE;
        M_STEP: ph = halt_in ? M_HALT : M_IDLE;
        M_HALT: if (edg) begin ph = M_HOLD; hold_left = RST_CYCLES - 1; end
        default: ;
      endcase
      hist = {hist[1:0], trigger};
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  int en_total = 0;
  int valid_total = 0;

  initial forever begin
    @(negedge clk);
    if (live) begin
      check("core_rst",    64'(core_rst),    64'(ph == M_HOLD));
      check("core_en",     64'(core_en),     64'((ph == M_RUN) || (ph == M_STEP)));
      check("halted",      64'(halted),      64'(ph == M_HALT));
      check("a0_out",      64'(a0_out),      64'(m_a0));
      check("a0_valid",    64'(a0_valid),    64'(m_valid));
      check("cycle_count", 64'(cycle_count), 64'(m_cnt));
    end
    if (core_en === 1'b1) en_total++;
    if (a0_valid === 1'b1) valid_total++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    mode = m;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(5);
  endtask

  int rst_hi, first_en, en_base, val_base;

  initial begin
    rst = 1'b1; trigger = 1'b0; mode = 2'd0; halt_in = 1'b0; a0_in = '0;

    // FREE: two reset cycles, core_rst held four cycles, then running
    step(2);
    rst = 1'b0;
    check("rst_core_en",   64'(core_en),     64'd0);
    check("rst_halted",    64'(halted),      64'd0);
    check("rst_a0_valid",  64'(a0_valid),    64'd0);
    check("rst_a0_out",    64'(a0_out),      64'd0);
    check("rst_count",     64'(cycle_count), 64'd0);
    rst_hi = 0; first_en = -1;
    for (int i = 0; i < 6; i++) begin
      if (core_rst) rst_hi++;
      if (core_en && first_en < 0) first_en = i;
      step();
    end
    check("free_rst_len",  64'(rst_hi),   64'd4);
    check("free_first_en", 64'(first_en), 64'd4);
    step(8);
    check("free_count10",  64'(cycle_count), 64'd10);

    // START: enable exactly two edges after the first sample, then halt
    do_reset(2'd1);
    check("start_idle", 64'(core_en), 64'd0);
    trigger = 1'b1;
    step(); check("start_lat_k0", 64'(core_en), 64'd0);
    step(); check("start_lat_k1", 64'(core_en), 64'd0);
    step(); check("start_lat_k2", 64'(core_en), 64'd1);
    trigger = 1'b0;
    step(3);
    halt_in = 1'b1;
    step();
    check("start_halted",   64'(halted),      64'd1);
    check("start_halt_en",  64'(core_en),     64'd0);
    check("start_count",    64'(cycle_count), 64'd4);
    halt_in = 1'b0;
    step(3);
    check("start_frozen",   64'(cycle_count), 64'd4);

    // STEP: five separated pulses with a0 ramping
    do_reset(2'd2);
    en_base = en_total; val_base = valid_total;
    for (int p = 1; p <= 5; p++) begin
      a0_in = XLEN'(p);
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      step(5);
    end
    check("step_en_pulses", 64'(en_total - en_base),    64'd5);
    check("step_count",     64'(cycle_count),           64'd5);
    check("step_a0_out",    64'(a0_out),                64'd5);
    check("step_valids",    64'(valid_total - val_base), 64'd5);

    // GATED: eight high samples give eight enabled cycles
    do_reset(2'd3);
    en_base = en_total;
    trigger = 1'b1;
    step(8);
    trigger = 1'b0;
    step(6);
    check("gated_en_cycles", 64'(en_total - en_base), 64'd8);
    check("gated_idle",      64'(core_en),            64'd0);
    trigger = 1'b1;
    step(4);
    trigger = 1'b0;
    step(2);
    check("gated_still_run", 64'(core_en), 64'd1);
    halt_in = 1'b1;
    step();
    check("gated_halt_wins", 64'(halted), 64'd1);
    halt_in = 1'b0;

    // Restart from HALTED with FREE latched; later mode changes ignored
    mode = 2'd0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    check("restart_wait",   64'(halted),      64'd1);
    step(); check("restart_rst", 64'(core_rst), 64'd1);
    step(); check("restart_cnt0", 64'(cycle_count), 64'd0);
    step(2); check("restart_rst_end", 64'(core_rst), 64'd1);
    step();
    check("restart_run",    64'(core_en),  64'd1);
    check("restart_rst_lo", 64'(core_rst), 64'd0);
    mode = 2'd2;
    step(5);
    check("mode_ignored_en",  64'(core_en),     64'd1);
    check("mode_ignored_cnt", 64'(cycle_count), 64'd5);

    // Saturation with a constant a0
    mode = 2'd0;
    a0_in = 32'd7;
    rst = 1'b1;
    step();
    rst = 1'b0;
    val_base = valid_total;
    step(24);
    check("sat_count",  64'(cycle_count),            64'd15);
    check("sat_valids", 64'(valid_total - val_base), 64'd1);
    check("sat_a0_out", 64'(a0_out),                 64'd7);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) trigger = ~trigger;
      halt_in = ($urandom_range(0, 11) == 0);
      mode    = 2'($urandom_range(0, 3));
      a0_in   = XLEN'($urandom_range(0, 3));
      rst     = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
